cov_deflate_stream: RTL and testbench



---
 rtl/fecg_pkg.sv | 43 ++++
 rtl/cov_deflate_stream_lane.sv | 64 ++++++
 rtl/cov_deflate_stream.sv | 196 +++++++++++++++++++
 tb/tb_cov_deflate_stream.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fecg_pkg.sv
// Shared types and saturation helper for the covariance deflation engine.
package fecg_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_FRAC_W = 16;
    localparam int WIDE_W     = 2 * PKG_DATA_W + 1;

    typedef logic signed [PKG_DATA_W-1:0] data_t;
    typedef logic signed [WIDE_W-1:0]     wide_t;

    typedef struct packed {
        data_t val;
        logic  sat;
    } sat_res_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam wide_t SAT_MAX = wide_t'({(PKG_DATA_W-1){1'b1}});
    localparam wide_t SAT_MIN = ~SAT_MAX;

    // Clamp a wide signed value into data_t range, flagging any clamp.
    function automatic sat_res_t sat_narrow(input wide_t wide);
        sat_res_t res;
        if (wide > SAT_MAX) begin
            res.val = {1'b0, {(PKG_DATA_W-1){1'b1}}};
            res.sat = 1'b1;
        end else if (wide < SAT_MIN) begin
            res.val = {1'b1, {(PKG_DATA_W-1){1'b0}}};
            res.sat = 1'b1;
        end else begin
            res.val = wide[PKG_DATA_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cov_deflate_stream_lane.sv
// One output column of the deflation datapath: stage 1 forms (lv*v)>>>FRAC_W,
// stage 2 subtracts it from the input element and saturates. Both stages hold
// while en is low so a stalled output stays stable.
module deflate_lane
    import fecg_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int FRAC_W = PKG_FRAC_W
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  data_t lv,
    input  data_t v,
    input  data_t in_elem,
    output data_t out_elem,
    output logic  sat
);

    wide_t    prod_q, prod_d;
    data_t    in_q, in_d;
    data_t    out_q, out_d;
    logic     sat_q, sat_d;

    logic signed [2*DATA_W-1:0] full;
    wide_t    in_ext;
    sat_res_t res;

    // Compute both stages; registers only take new values when the pipe advances.
    always_comb begin
        full   = (2*DATA_W)'(lv) * (2*DATA_W)'(v);
        in_ext = wide_t'(in_q);
        res    = sat_narrow(in_ext - prod_q);
        prod_d = prod_q;
        in_d   = in_q;
        out_d  = out_q;
        sat_d  = sat_q;
        if (en) begin
            prod_d = wide_t'(full >>> FRAC_W);
            in_d   = in_elem;
            out_d  = res.val;
            sat_d  = res.sat;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            in_q   <= '0;
            out_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            in_q   <= in_d;
            out_q  <= out_d;
            sat_q  <= sat_d;
        end
    end

    assign out_elem = out_q;
    assign sat      = sat_q;

endmodule

// File: rtl/cov_deflate_stream.sv
// Streaming covariance deflation: C_out = C_in - lambda * v * v^T, one row per beat.
// Holds the pass FSM, latched operands, the scaled vector lv = lambda*v, row
// counters and the valid pipeline that shadows the per-column lanes.
module cov_deflate_stream
    import fecg_pkg::*;
#(
    parameter int SIZE_N = 8,
    parameter int DATA_W = PKG_DATA_W,
    parameter int FRAC_W = PKG_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     deflate_en,
    input  logic [SIZE_N*DATA_W-1:0] vec,
    input  logic [DATA_W-1:0]        eigval,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE_N*DATA_W-1:0] in_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_N*DATA_W-1:0] out_row,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);

    localparam int CNT_W = $clog2(SIZE_N + 1);
    localparam int IDX_W = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam logic [CNT_W-1:0] ROWS_N   = CNT_W'(SIZE_N);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(SIZE_N - 1);

    state_t            state_q, state_d;
    data_t             v_q  [SIZE_N];
    data_t             v_d  [SIZE_N];
    data_t             lv_q [SIZE_N];
    data_t             lv_d [SIZE_N];
    data_t             eig_q, eig_d;
    logic              den_q, den_d;
    logic [CNT_W-1:0]  rows_in_q, rows_in_d;
    logic [CNT_W-1:0]  rows_out_q, rows_out_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic              sat_flag_q, sat_flag_d;

    logic              advance;
    logic              accept;
    logic              out_hs;
    data_t             lv_row;
    sat_res_t          lv_res;
    data_t             lane_out [SIZE_N];
    logic [SIZE_N-1:0] lane_sat;

    // lv[i] = sat((lambda * v[i]) >>> FRAC_W), computed once per pass in PREP.
    function automatic sat_res_t scale_lv(input data_t lam, input data_t vi);
        logic signed [2*DATA_W-1:0] full;
        full = (2*DATA_W)'(lam) * (2*DATA_W)'(vi);
        return sat_narrow(wide_t'(full >>> FRAC_W));
    endfunction

    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = (state_q == STREAM) && (rows_in_q < ROWS_N) && advance;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;

    // Select the scale for the row entering stage 1; zero makes the lanes pass rows through.
    always_comb begin
        lv_row = '0;
        if (den_q && (rows_in_q < ROWS_N)) begin
            lv_row = lv_q[rows_in_q[IDX_W-1:0]];
        end
    end

    // Next-state, operand latching, counters, valid pipeline and sticky saturation.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        lv_d       = lv_q;
        eig_d      = eig_q;
        den_d      = den_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        sat_flag_d = sat_flag_q;
        lv_res     = '0;

        if (advance) begin
            s1_valid_d = accept;
            s2_valid_d = s1_valid_q;
        end
        if (accept) begin
            rows_in_d = rows_in_q + 1'b1;
        end
        if (out_hs) begin
            rows_out_d = rows_out_q + 1'b1;
        end
        if (s2_valid_q && (|lane_sat)) begin
            sat_flag_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < SIZE_N; i++) begin
                        v_d[i] = vec[i*DATA_W +: DATA_W];
                    end
                    eig_d      = eigval;
                    den_d      = deflate_en;
                    sat_flag_d = 1'b0;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                for (int i = 0; i < SIZE_N; i++) begin
                    lv_res  = scale_lv(eig_q, v_q[i]);
                    lv_d[i] = lv_res.val;
                    if (den_q && lv_res.sat) begin
                        sat_flag_d = 1'b1;
                    end
                end
                state_d = STREAM;
            end
            STREAM: begin
                if (accept && (rows_in_q == LAST_ROW)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && (rows_out_q == LAST_ROW)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and operand registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            v_q        <= '{default: '0};
            lv_q       <= '{default: '0};
            eig_q      <= '0;
            den_q      <= 1'b0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            lv_q       <= lv_d;
            eig_q      <= eig_d;
            den_q      <= den_d;
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    for (genvar c = 0; c < SIZE_N; c++) begin : g_lane
        deflate_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .lv       (lv_row),
            .v        (v_q[c]),
            .in_elem  (in_row[c*DATA_W +: DATA_W]),
            .out_elem (lane_out[c]),
            .sat      (lane_sat[c])
        );
        assign out_row[c*DATA_W +: DATA_W] = lane_out[c];
    end

    assign out_valid = s2_valid_q;
    assign out_last  = s2_valid_q && (rows_out_q == LAST_ROW);
    assign busy      = (state_q == PREP) || (state_q == STREAM) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_cov_deflate_stream.sv
// Randomized bench for cov_deflate_stream against an integer-arithmetic model.
module tb_cov_deflate_stream;

    localparam int N = 4;
    localparam int W = 32;
    localparam int F = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           deflate_en;
    logic [N*W-1:0] vec;
    logic [W-1:0]   eigval;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_row;
    logic           out_last;
    logic           busy;
    logic           done;
    logic           sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]    m_vec  [N];
    logic [31:0]    m_lam;
    logic           m_den;
    logic [31:0]    m_rows [N][N];
    logic [N*W-1:0] exp_rows [N];
    logic           exp_sat;
    logic [N*W-1:0] first_row;

    always #5 clk = ~clk;

    cov_deflate_stream #(
        .SIZE_N (N),
        .DATA_W (W),
        .FRAC_W (F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .deflate_en (deflate_en),
        .vec        (vec),
        .eigval     (eigval),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint clamp32(input longint x, output logic hit);
        hit = 1'b0;
        if (x > 64'sd2147483647) begin
            hit = 1'b1;
            return 64'sd2147483647;
        end
        if (x < -64'sd2147483648) begin
            hit = 1'b1;
            return -64'sd2147483648;
        end
        return x;
    endfunction

    function automatic logic [N*W-1:0] pack_row(input int r);
        logic [N*W-1:0] row;
        for (int c = 0; c < N; c++) row[c*W +: W] = m_rows[r][c];
        return row;
    endfunction

    function automatic logic [N*W-1:0] pack_vec();
        logic [N*W-1:0] pv;
        for (int i = 0; i < N; i++) pv[i*W +: W] = m_vec[i];
        return pv;
    endfunction

    function automatic logic [31:0] rand_val(input int mode);
        int s;
        case (mode)
            0: begin
                s = int'($urandom_range(0, 262143)) - 131072;
                return 32'(s);
            end
            1: return $urandom;
            default: return ($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'h0;
        endcase
    endfunction

    // Reference: C_out = sat(C - ((sat(lambda*v >>> F) * v) >>> F)) elementwise.
    task automatic compute_model();
        longint lvs [N];
        longint d;
        logic   hit;
        exp_sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            lvs[i] = clamp32((longint'($signed(m_lam)) * longint'($signed(m_vec[i]))) >>> F, hit);
            if (m_den && hit) exp_sat = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                d = longint'($signed(m_rows[r][c]));
                if (m_den) begin
                    d = clamp32(d - ((lvs[r] * longint'($signed(m_vec[c]))) >>> F), hit);
                    if (hit) exp_sat = 1'b1;
                end
                exp_rows[r][c*W +: W] = d[31:0];
            end
        end
    endtask

    task automatic randomize_pass(input int mode);
        for (int i = 0; i < N; i++) m_vec[i] = rand_val(mode);
        m_lam = rand_val(mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_rows[r][c] = rand_val(mode);
    endtask

    // Run one full matrix pass with random handshake pressure and check every row.
    task automatic applyStimulus(input int ready_pct, input int valid_pct);
        int             sent = 0;
        int             got = 0;
        int             accepts = 0;
        int             acc_cyc [N];
        logic           stalled = 1'b0;
        logic           seen_done = 1'b0;
        logic [N*W-1:0] held_row = '0;

        compute_model();
        start      = 1'b1;
        vec        = pack_vec();
        eigval     = m_lam;
        deflate_en = m_den;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 300 && !seen_done; k++) begin
            if (sent < N) begin
                in_valid = ($urandom_range(0, 99) < valid_pct);
                in_row   = pack_row(sent);
            end else begin
                in_valid = (valid_pct == 100);
                in_row   = {$urandom, $urandom, $urandom, $urandom};
            end
            out_ready  = ($urandom_range(0, 99) < ready_pct);
            start      = (got == N) ? 1'b1 : ($urandom_range(0, 7) == 0);
            vec        = {$urandom, $urandom, $urandom, $urandom};
            eigval     = $urandom;
            deflate_en = $urandom_range(0, 1);

            @(negedge clk);
            if (k == 0) begin
                checkOutput("sat_clr", sat_flag, 1'b0);
                checkOutput("prep_busy", busy, 1'b1);
                checkOutput("prep_in_ready", in_ready, 1'b0);
            end
            if (stalled) begin
                checkOutput("hold_valid", out_valid, 1'b1);
                checkOutput("hold_row", out_row, held_row);
            end
            if (out_valid && out_ready) begin
                if (got < N) begin
                    checkOutput($sformatf("row%0d", got), out_row, exp_rows[got]);
                    checkOutput("out_last", out_last, (got == N - 1));
                    if (ready_pct == 100) checkOutput("latency", k - acc_cyc[got], 2);
                    if (got == 0) first_row = out_row;
                end else begin
                    checkOutput("row_count", got + 1, N);
                end
                got++;
            end
            stalled  = out_valid && !out_ready;
            held_row = out_row;
            if (in_valid && in_ready) begin
                if (sent < N) begin
                    acc_cyc[sent] = k;
                    sent++;
                end
                accepts++;
            end
            if (done) begin
                seen_done = 1'b1;
                checkOutput("done_after_last", got, N);
            end
            @(posedge clk); #1;
        end

        checkOutput("pass_done", seen_done, 1'b1);
        checkOutput("rows_in", accepts, N);
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("done_pulse", done, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("pass_sat", sat_flag, exp_sat);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;

        rst        = 1'b0;
        start      = 1'b0;
        deflate_en = 1'b0;
        vec        = '0;
        eigval     = '0;
        in_valid   = 1'b1;
        in_row     = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_last", out_last, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_sat", sat_flag, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        $display("[TB] T1 unit vector, lambda 2.0, C = 3I");
        m_vec = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        m_lam = 32'h0002_0000;
        m_den = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_rows[r][c] = (r == c) ? 32'h0003_0000 : 32'h0;
        applyStimulus(100, 100);

        $display("[TB] T2 v = 0.5s, lambda 4.0, C all ones");
        m_vec = '{32'h8000, 32'h8000, 32'h8000, 32'h8000};
        m_lam = 32'h0004_0000;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_rows[r][c] = 32'h0001_0000;
        applyStimulus(100, 100);

        $display("[TB] T3 pass-through");
        randomize_pass(1);
        m_den = 1'b0;
        applyStimulus(100, 100);

        $display("[TB] T4 positive saturation");
        m_vec = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
        m_lam = 32'h8001_0000;
        m_den = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_rows[r][c] = 32'h0;
        m_rows[0][0] = 32'h7FFF_0000;
        applyStimulus(100, 100);
        checkOutput("t4_elem00", first_row[31:0], 32'h7FFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_sat_sticky", sat_flag, 1'b1);

        $display("[TB] T5 random backpressure");
        randomize_pass(0);
        m_den = 1'b1;
        applyStimulus(50, 100);

        $display("[TB] random passes");
        for (int p = 0; p < 8; p++) begin
            randomize_pass($urandom_range(0, 2));
            m_den = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("[TB] T6 reset mid-stream");
        randomize_pass(0);
        m_den      = 1'b1;
        start      = 1'b1;
        vec        = pack_vec();
        eigval     = m_lam;
        deflate_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent  = 0;
        for (int k = 0; k < 50 && sent < 2; k++) begin
            in_valid  = 1'b1;
            in_row    = pack_row(sent);
            out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        checkOutput("t6_rows_before_reset", sent, 2);
        rst = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_out_valid", out_valid, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_sat", sat_flag, 1'b0);
        checkOutput("t6_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t6_no_done", done, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        applyStimulus(100, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
